// File: rtl/decade_pair_sequencer.sv
`default_nettype none
// ============================================================================
// decade_pair_sequencer : strobe sequencer for a tens/units up/down counter pair
// Revision: 1.0
// ============================================================================
module decade_pair_sequencer #(
  parameter int MODULUS = 60,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       tick,
  input  logic       set_up,
  input  logic       set_dn,
  input  logic       load_req,
  input  logic [7:0] load_val,
  output logic       u_cpu,
  output logic       u_cpd,
  output logic       t_cpu,
  output logic       t_cpd,
  output logic       pl_n,
  output logic [7:0] p_out,
  output logic [7:0] shadow,
  output logic       carry,
  output logic       borrow,
  output logic       busy,
  output logic       err
);

  localparam int              MAX_W      = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int              CW         = $clog2(MAX_W + 1);
  localparam logic [3:0]      TOP_T      = 4'((MODULUS - 1) / 10);
  localparam logic [3:0]      TOP_U      = 4'((MODULUS - 1) % 10);
  localparam logic [7:0]      TOP_BCD    = {TOP_T, TOP_U};
  localparam logic [7:0]      MOD_BIN    = 8'(MODULUS);
  localparam logic [CW-1:0]   PULSE_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0]   GAP_LAST   = CW'(GAP_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          u_cpu_q, u_cpu_d, u_cpd_q, u_cpd_d;
  logic          t_cpu_q, t_cpu_d, t_cpd_q, t_cpd_d;
  logic          pl_n_q, pl_n_d;
  logic [7:0]    p_out_q, p_out_d;
  logic [7:0]    shadow_q, shadow_d;
  logic          carry_q, carry_d, borrow_q, borrow_d;
  logic          busy_q, busy_d, err_q, err_d;
  logic          pend_q, pend_d;

  logic [3:0]    sh_t, sh_u, ld_t, ld_u;
  logic [7:0]    ld_bin;
  logic          ld_ok, at_top, at_zero;
  logic          go_load, go_up, go_dn, tick_lost;

  assign sh_t    = shadow_q[7:4];
  assign sh_u    = shadow_q[3:0];
  assign ld_t    = load_val[7:4];
  assign ld_u    = load_val[3:0];
  assign ld_bin  = ({4'd0, ld_t} * 8'd10) + {4'd0, ld_u};
  assign ld_ok   = (ld_t <= 4'd9) && (ld_u <= 4'd9) && (ld_bin < MOD_BIN);
  assign at_top  = (shadow_q == TOP_BCD);
  assign at_zero = (shadow_q == 8'h00);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    u_cpu_d   = u_cpu_q;
    u_cpd_d   = u_cpd_q;
    t_cpu_d   = t_cpu_q;
    t_cpd_d   = t_cpd_q;
    pl_n_d    = pl_n_q;
    p_out_d   = p_out_q;
    shadow_d  = shadow_q;
    carry_d   = 1'b0;
    borrow_d  = 1'b0;
    busy_d    = busy_q;
    err_d     = 1'b0;
    pend_d    = pend_q;
    go_load   = 1'b0;
    go_up     = 1'b0;
    go_dn     = 1'b0;
    tick_lost = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          go_load   = ld_ok;
          err_d     = !ld_ok;
          tick_lost = tick;
        end else if (set_up) begin
          go_up     = 1'b1;
          tick_lost = tick;
        end else if (set_dn) begin
          go_dn     = 1'b1;
          tick_lost = tick;
        end else if (tick || pend_q) begin
          // A fresh tick on top of a pending one is an overrun: serve one, drop one.
          go_up  = 1'b1;
          pend_d = 1'b0;
          if (tick && pend_q) begin
            err_d = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        tick_lost = tick;
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LAST;
          u_cpu_d = 1'b1;
          u_cpd_d = 1'b1;
          t_cpu_d = 1'b1;
          t_cpd_d = 1'b1;
          pl_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        tick_lost = tick;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (tick_lost) begin
      if (pend_q) begin
        err_d = 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end

    if (go_load || go_up || go_dn) begin
      state_d = ST_PULSE;
      cnt_d   = PULSE_LAST;
      busy_d  = 1'b1;
      if (go_load) begin
        pl_n_d   = 1'b0;
        p_out_d  = load_val;
        shadow_d = load_val;
      end else if (go_up) begin
        if (at_top) begin
          pl_n_d   = 1'b0;
          p_out_d  = 8'h00;
          shadow_d = 8'h00;
          carry_d  = 1'b1;
        end else if (sh_u == 4'd9) begin
          u_cpu_d  = 1'b0;
          t_cpu_d  = 1'b0;
          shadow_d = {sh_t + 4'd1, 4'd0};
        end else begin
          u_cpu_d  = 1'b0;
          shadow_d = {sh_t, sh_u + 4'd1};
        end
      end else begin
        if (at_zero) begin
          pl_n_d   = 1'b0;
          p_out_d  = TOP_BCD;
          shadow_d = TOP_BCD;
          borrow_d = 1'b1;
        end else if (sh_u == 4'd0) begin
          u_cpd_d  = 1'b0;
          t_cpd_d  = 1'b0;
          shadow_d = {sh_t - 4'd1, 4'd9};
        end else begin
          u_cpd_d  = 1'b0;
          shadow_d = {sh_t, sh_u - 4'd1};
        end
      end
    end
  end

  // Every output is a flop, so strobes switch cleanly on state entry only.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      u_cpu_q  <= 1'b1;
      u_cpd_q  <= 1'b1;
      t_cpu_q  <= 1'b1;
      t_cpd_q  <= 1'b1;
      pl_n_q   <= 1'b1;
      p_out_q  <= 8'h00;
      shadow_q <= 8'h00;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      u_cpu_q  <= u_cpu_d;
      u_cpd_q  <= u_cpd_d;
      t_cpu_q  <= t_cpu_d;
      t_cpd_q  <= t_cpd_d;
      pl_n_q   <= pl_n_d;
      p_out_q  <= p_out_d;
      shadow_q <= shadow_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
    end
  end

  assign u_cpu  = u_cpu_q;
  assign u_cpd  = u_cpd_q;
  assign t_cpu  = t_cpu_q;
  assign t_cpd  = t_cpd_q;
  assign pl_n   = pl_n_q;
  assign p_out  = p_out_q;
  assign shadow = shadow_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decade_pair_sequencer.sv
`default_nettype none
// ============================================================================
// tb_decade_pair_sequencer : directed scoreboard bench for decade_pair_sequencer
// Revision: 1.0
// ============================================================================
module tb_decade_pair_sequencer;

  localparam int MOD = 60;

  logic       clk = 1'b0;
  logic       mr = 1'b1;
  logic       tick = 1'b0, set_up = 1'b0, set_dn = 1'b0, load_req = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       u_cpu, u_cpd, t_cpu, t_cpd, pl_n;
  logic [7:0] p_out, shadow;
  logic       carry, borrow, busy, err;

  decade_pair_sequencer #(.MODULUS(MOD), .PULSE_W(2), .GAP_W(2)) dut (
    .clk(clk), .mr(mr), .tick(tick), .set_up(set_up), .set_dn(set_dn),
    .load_req(load_req), .load_val(load_val),
    .u_cpu(u_cpu), .u_cpd(u_cpd), .t_cpu(t_cpu), .t_cpd(t_cpd), .pl_n(pl_n),
    .p_out(p_out), .shadow(shadow), .carry(carry), .borrow(borrow),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // strb = {u_cpu, u_cpd, t_cpu, t_cpd, pl_n}
  typedef struct packed {
    logic [4:0] strb;
    logic [7:0] p;
    logic [7:0] sh;
    logic       c;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   mv = 0;
  int   errors = 0, checks = 0;
  int   carry_cnt = 0, borrow_cnt = 0, err_cnt = 0;
  logic prev_high = 1'b1;
  logic excl_ok;
  wire [4:0] strb = {u_cpu, u_cpd, t_cpu, t_cpd, pl_n};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic push_up();
    exp_t e;
    e = '0;
    if (mv == MOD - 1) begin
      e.strb = 5'b11110; e.p = 8'h00; e.c = 1'b1;
    end else if (mv % 10 == 9) begin
      e.strb = 5'b01011;
    end else begin
      e.strb = 5'b01111;
    end
    mv   = (mv + 1) % MOD;
    e.sh = to_bcd(mv);
    sb.push_back(e);
  endtask

  task automatic push_dn();
    exp_t e;
    e = '0;
    if (mv == 0) begin
      e.strb = 5'b11110; e.p = to_bcd(MOD - 1); e.b = 1'b1;
    end else if (mv % 10 == 0) begin
      e.strb = 5'b10101;
    end else begin
      e.strb = 5'b10111;
    end
    mv   = (mv + MOD - 1) % MOD;
    e.sh = to_bcd(mv);
    sb.push_back(e);
  endtask

  task automatic push_load(input int v);
    exp_t e;
    e = '0;
    e.strb = 5'b11110; e.p = to_bcd(v); e.sh = to_bcd(v);
    mv = v;
    sb.push_back(e);
  endtask

  task automatic strobe_in(input bit ld, input bit su, input bit sd, input bit tk,
                           input logic [7:0] val);
    @(posedge clk); #1;
    load_req = ld; set_up = su; set_dn = sd; tick = tk; load_val = val;
    @(posedge clk); #1;
    load_req = 1'b0; set_up = 1'b0; set_dn = 1'b0; tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Monitor: pop an expected op whenever strobes leave the all-high state.
  always @(negedge clk) begin
    if (mr) begin
      prev_high = 1'b1;
    end else begin
      excl_ok = !(!u_cpu && !u_cpd) && !(!t_cpu && !t_cpd) &&
                !(!pl_n && (!u_cpu || !u_cpd || !t_cpu || !t_cpd));
      chk("strobe_excl", 32'(excl_ok), 32'd1);
      if (carry)  carry_cnt++;
      if (borrow) borrow_cnt++;
      if (err)    err_cnt++;
      if (strb != 5'b11111 && prev_high) begin
        if (sb.size() == 0) begin
          chk("unexpected_op", 32'(strb), 32'h1f);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("op_strobes", 32'(strb), 32'(e.strb));
          chk("op_shadow", 32'(shadow), 32'(e.sh));
          chk("op_carry", 32'(carry), 32'(e.c));
          chk("op_borrow", 32'(borrow), 32'(e.b));
          if (!pl_n) chk("op_p_out", 32'(p_out), 32'(e.p));
        end
      end
      prev_high = (strb == 5'b11111);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    repeat (2) @(negedge clk);
    chk("rst_strobes", 32'(strb), 32'h1f);
    chk("rst_p_out", 32'(p_out), 32'h00);
    chk("rst_shadow", 32'(shadow), 32'h00);
    chk("rst_flags", 32'({carry, borrow, busy, err}), 32'h0);
    @(posedge clk); #1;
    mr = 1'b0;

    // 60 spaced ticks: full lap with one carry
    for (int i = 0; i < 60; i++) begin
      push_up();
      strobe_in(0, 0, 0, 1, 8'h00);
      repeat (8) @(posedge clk);
    end
    wait_idle();
    chk("t1_shadow", 32'(shadow), 32'h00);
    chk("t1_carry_cnt", 32'(carry_cnt), 32'd1);
    chk("t1_drain", 32'(sb.size()), 32'd0);

    // load 23 then count down through zero
    push_load(23);
    strobe_in(1, 0, 0, 0, 8'h23);
    wait_idle();
    for (int i = 0; i < 23; i++) begin
      push_dn();
      strobe_in(0, 0, 1, 0, 8'h00);
      wait_idle();
    end
    chk("t2_shadow_zero", 32'(shadow), 32'h00);
    push_dn();
    strobe_in(0, 0, 1, 0, 8'h00);
    wait_idle();
    chk("t2_shadow_wrap", 32'(shadow), 32'h59);
    chk("t2_borrow_cnt", 32'(borrow_cnt), 32'd1);

    // illegal loads
    e0 = err_cnt;
    strobe_in(1, 0, 0, 0, 8'h5A);
    repeat (3) @(posedge clk);
    chk("t3_err_digit", 32'(err_cnt - e0), 32'd1);
    strobe_in(1, 0, 0, 0, 8'h60);
    repeat (3) @(posedge clk);
    chk("t3_err_range", 32'(err_cnt - e0), 32'd2);
    chk("t3_shadow", 32'(shadow), 32'h59);
    chk("t3_busy", 32'(busy), 32'd0);

    // back-to-back ticks: one accepted, one pending, rest overrun
    e0 = err_cnt;
    push_up();
    push_up();
    @(posedge clk); #1;
    tick = 1'b1;
    repeat (5) @(posedge clk);
    #1 tick = 1'b0;
    repeat (12) @(posedge clk);
    #1 wait_idle();
    chk("t4_err_cnt", 32'(err_cnt - e0), 32'd3);
    chk("t4_shadow", 32'(shadow), 32'h01);
    chk("t4_carry_cnt", 32'(carry_cnt), 32'd2);

    // simultaneous set_up/set_dn/tick at 08
    push_load(8);
    strobe_in(1, 0, 0, 0, 8'h08);
    wait_idle();
    push_up();
    push_up();
    strobe_in(0, 1, 1, 1, 8'h00);
    repeat (12) @(posedge clk);
    #1 wait_idle();
    chk("t5_shadow", 32'(shadow), 32'h10);
    chk("t5_drain", 32'(sb.size()), 32'd0);

    // reset in the middle of a load pulse
    push_load(45);
    strobe_in(1, 0, 0, 0, 8'h45);
    @(posedge clk); #1;
    mr = 1'b1;
    #1;
    chk("t6_strobes", 32'(strb), 32'h1f);
    chk("t6_shadow", 32'(shadow), 32'h00);
    chk("t6_busy", 32'(busy), 32'd0);
    mv = 0;
    repeat (2) @(posedge clk);
    #1 mr = 1'b0;
    @(posedge clk); #1;
    chk("t6_idle", 32'(busy), 32'd0);
    push_up();
    strobe_in(0, 0, 0, 1, 8'h00);
    wait_idle();
    chk("t6_shadow_after", 32'(shadow), 32'h01);
    repeat (3) @(posedge clk);
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
